ring_step_ctrl: RTL
===================

Name: ring_step_ctrl

Overview:
Command-driven sequencer for the 4-bit one-hot ring counter (fsm: cnt, clk, rst_n, y). It accepts ADVANCE-by-N or SEEK-to-position commands over a valid/ready handshake. It then issues paced single-cycle cnt pulses to the counter and monitors the counter's y output as feedback. It sits between the control logic and the ring counter, and is the only driver of the counter's cnt input.

Parameters:
STEP_W, 8, width of the step count and of the pulse counter.
GAP, 1, idle cycles after each cnt pulse (legal range 1..15); lets y settle before it is sampled.
SEEK_MAX, 4, maximum pulses allowed in a SEEK before it times out.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command (high only in IDLE).
cmd_mode  in  1  0 = ADVANCE, 1 = SEEK.
cmd_steps  in  STEP_W  pulse count for ADVANCE; ignored for SEEK.
cmd_target  in  4  one-hot target position for SEEK; ignored for ADVANCE.
abort  in  1  synchronous abort of the active command.
y_fb  in  4  ring counter output y.
cnt  out  1  step pulse to the ring counter.
busy  out  1  command in progress (high in any state except IDLE).
done  out  1  one-cycle completion pulse.
status  out  2  result, valid when done=1: 00 ok, 01 bad target, 10 seek timeout, 11 aborted.
pulses  out  STEP_W  number of cnt pulses issued for the current or last command.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE, cnt=0, busy=0, done=0, status=00, pulses=0, cmd_ready=1.
  - Reset mid-command drops the command immediately. The ring counter is not touched.
- All outputs decode from registers. There is no combinational path from any input to any output.
- States: IDLE, PULSE, GAP, DONE.
- IDLE:
  - Acceptance happens on a clock edge with cmd_valid=1 and cmd_ready=1. At that edge the controller captures the mode, steps and target, and clears pulses to 0.
  - ADVANCE, steps=0 -> DONE, status 00.
  - SEEK, target not exactly one-hot -> DONE, status 01, zero pulses.
  - SEEK, target == y_fb at the acceptance edge -> DONE, status 00, zero pulses.
  - Otherwise -> PULSE.
- PULSE:
  - Lasts exactly 1 cycle with cnt=1; pulses increments by 1 at the exit edge.
  - ADVANCE decrements its remaining count at the same edge.
  - Always exits to GAP.
- GAP:
  - Lasts GAP cycles with cnt=0. The decision below is taken at the edge ending the last GAP cycle, using y_fb sampled in that cycle.
  - ADVANCE: remaining=0 -> DONE, status 00; else -> PULSE.
  - SEEK: y_fb == target -> DONE, status 00.
  - SEEK: otherwise, pulses >= SEEK_MAX -> DONE, status 10 (counter stuck or wrong width); otherwise -> PULSE.
- DONE:
  - Lasts 1 cycle with done=1 and status valid; busy stays 1 during this cycle.
  - Returns to IDLE. status and pulses hold until the next acceptance.
- ADVANCE latency: for N>0, cycle 1 (the first cycle after acceptance) is the first PULSE. done is high in cycle N*(1+GAP)+1.
- Zero-pulse completions (steps=0, bad target, already at target): done is high in cycle 1.
- Abort:
  - Sampled in PULSE or GAP -> DONE next cycle, status 11.
  - An abort sampled in PULSE does not suppress the cnt already high in that cycle; that pulse is counted.
  - Abort is ignored in IDLE and DONE.
  - If abort coincides with a normal completion decision in GAP, abort wins (status 11).
- cmd_valid while busy is ignored; cmd_ready=0 guarantees no capture.
- A new command can be accepted in the cycle after DONE at the earliest.
- pulses saturates at all-ones and does not wrap; ADVANCE still issues exactly cmd_steps pulses.
- cnt is never high for two consecutive cycles, and is never high in IDLE or DONE.

Test Plan:
Assume GAP=1 and a ring counter at 0001 after reset.
- Reset then idle -> cnt=0, busy=0, done=0, cmd_ready=1, status=00, pulses=0.
- ADVANCE steps=3 -> cnt high in cycles 1, 3, 5; y goes 0010, 0100, 1000; done in cycle 7; status=00; pulses=3.
- ADVANCE steps=5 from 0001 -> y wraps to 0010; pulses=5; done in cycle 11.
- SEEK target=1000 from 0001 -> 3 pulses, done with status=00, y=1000.
- SEEK target=0001 when already at 0001 -> done in cycle 1, 0 pulses.
- SEEK target=0110 -> done in cycle 1, status=01, no cnt.
- SEEK with y_fb forced to 0100 and target=0001 -> 4 pulses, then status=10.
- ADVANCE steps=10 with abort in cycle 4 (GAP) -> done in cycle 5, status=11, pulses=2.
- rst_n asserted mid-ADVANCE -> cnt=0 and busy=0 immediately, without waiting for a clock edge.
- cmd_valid held high during busy -> no second command is captured.

Source files
------------

// File: rtl/ring_step_ctrl_if.sv
// ring_step_ctrl_if: command handshake bundle between the control logic and ring_step_ctrl.
// Revision 1.0 - initial release
`default_nettype none

interface ring_step_ctrl_if #(
  parameter int STEP_W = 8
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_mode;
  logic [STEP_W-1:0] cmd_steps;
  logic [3:0]        cmd_target;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_steps,
    output cmd_target,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_steps,
    input  cmd_target,
    output cmd_ready
  );

endinterface

`default_nettype wire

// File: rtl/ring_step_ctrl.sv
// ring_step_ctrl: ADVANCE/SEEK command sequencer issuing paced cnt pulses to a 4-bit one-hot ring counter.
// Revision 1.0 - initial release
`default_nettype none

module ring_step_ctrl #(
  parameter int STEP_W   = 8,
  parameter int GAP      = 1,
  parameter int SEEK_MAX = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  ring_step_ctrl_if.slave        cmd,
  input  wire logic              abort,
  input  wire logic [3:0]        y_fb,
  output logic                   cnt,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status,
  output logic [STEP_W-1:0]      pulses
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_BAD   = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  localparam logic              MODE_ADV  = 1'b0;
  localparam logic [3:0]        GAP_LAST  = 4'(GAP - 1);
  localparam logic [STEP_W-1:0] SEEK_LIM  = STEP_W'(SEEK_MAX);
  localparam logic [STEP_W-1:0] PULSE_SAT = '1;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic [3:0]        target_q, target_d;
  logic [STEP_W-1:0] pulses_q, pulses_d;
  logic [1:0]        status_q, status_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              target_onehot;

  assign target_onehot = (cmd.cmd_target != 4'd0) &&
                         ((cmd.cmd_target & (cmd.cmd_target - 4'd1)) == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_ADV;
      remaining_q <= '0;
      target_q    <= 4'd0;
      pulses_q    <= '0;
      status_q    <= ST_OK;
      gap_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      target_q    <= target_d;
      pulses_q    <= pulses_d;
      status_q    <= status_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    target_d    = target_q;
    pulses_d    = pulses_q;
    status_d    = status_q;
    gap_cnt_d   = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          mode_d      = cmd.cmd_mode;
          remaining_d = cmd.cmd_steps;
          target_d    = cmd.cmd_target;
          pulses_d    = '0;
          status_d    = ST_OK;
          if (cmd.cmd_mode == MODE_ADV) begin
            state_d = (cmd.cmd_steps == '0) ? S_DONE : S_PULSE;
          end else if (!target_onehot) begin
            status_d = ST_BAD;
            state_d  = S_DONE;
          end else if (cmd.cmd_target == y_fb) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PULSE;
          end
        end
      end

      S_PULSE: begin
        // The pulse already on cnt this cycle is counted even when aborting.
        if (pulses_q != PULSE_SAT) begin
          pulses_d = pulses_q + 1'b1;
        end
        if (mode_q == MODE_ADV) begin
          remaining_d = remaining_q - 1'b1;
        end
        gap_cnt_d = GAP_LAST;
        if (abort) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else begin
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (abort) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else if (gap_cnt_q != 4'd0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else if (mode_q == MODE_ADV) begin
          state_d = (remaining_q == '0) ? S_DONE : S_PULSE;
        end else if (y_fb == target_q) begin
          state_d = S_DONE;
        end else if (pulses_q >= SEEK_LIM) begin
          // Counter did not reach the target within the pulse budget.
          status_d = ST_TMO;
          state_d  = S_DONE;
        end else begin
          state_d = S_PULSE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cnt           = (state_q == S_PULSE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign status        = status_q;
  assign pulses        = pulses_q;

endmodule

`default_nettype wire
